// File: rtl/spi_alu_pkg.sv
// Shared types and frame geometry for the SPI-to-ALU transaction controller.
package spi_alu_pkg;

  localparam int unsigned OPERAND_W = 4;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned FLAGS_W   = 4;

  localparam int unsigned FRAME_W = 2 * OPERAND_W + OPCODE_W;
  localparam int unsigned RESP_W  = OPERAND_W + FLAGS_W;

  // Response streamed back when the ALU never completes.
  localparam logic [RESP_W-1:0] TIMEOUT_RESP = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_EXEC,
    S_RESP
  } seq_state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register, serial in at the LSB so data leaves MSB first.
module spi_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         serial_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Load wins over shift when both are requested.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[W-2:0], serial_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_alu_sequencer.sv
// Receives an operand/operator frame over SPI, runs one ALU operation with a
// completion timeout, and streams {result, flags} back on MISO.
module spi_alu_sequencer
  import spi_alu_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 8
) (
  input  logic                 clk_arduino,
  input  logic                 reset,
  input  logic                 CS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  output logic [OPCODE_W-1:0]  alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [OPERAND_W-1:0] alu_result,
  input  logic [FLAGS_W-1:0]   alu_flags,
  output logic [OPERAND_W-1:0] leds,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int unsigned BIT_CNT_W = $clog2(FRAME_W);
  localparam int unsigned TX_CNT_W  = $clog2(RESP_W + 1);
  localparam int unsigned TO_CNT_W  = $clog2(ALU_TIMEOUT + 1);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);
  localparam logic [TX_CNT_W-1:0]  TX_LAST  = TX_CNT_W'(RESP_W - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(ALU_TIMEOUT - 1);

  seq_state_t state_q, state_d;

  logic                 miso_q, miso_d;
  logic [OPERAND_W-1:0] alu_a_q, alu_a_d;
  logic [OPERAND_W-1:0] alu_b_q, alu_b_d;
  logic [OPCODE_W-1:0]  alu_op_q, alu_op_d;
  logic                 alu_start_q, alu_start_d;
  logic [OPERAND_W-1:0] leds_q, leds_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TX_CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;

  logic                 rx_shift;
  logic [FRAME_W-1:0]   rx_data;
  logic [FRAME_W-1:0]   frame_nxt;
  logic                 tx_load;
  logic                 tx_shift;
  logic [RESP_W-1:0]    tx_load_data;
  logic [RESP_W-1:0]    tx_data;

  logic                 unused_rx_msb;
  logic                 unused_tx_bits;

  spi_shift_reg #(.W(FRAME_W)) u_rx (
    .clk_i       (clk_arduino),
    .rst_i       (reset),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (rx_shift),
    .serial_i    (MOSI),
    .data_o      (rx_data)
  );

  spi_shift_reg #(.W(RESP_W)) u_tx (
    .clk_i       (clk_arduino),
    .rst_i       (reset),
    .load_i      (tx_load),
    .load_data_i (tx_load_data),
    .shift_i     (tx_shift),
    .serial_i    (1'b0),
    .data_o      (tx_data)
  );

  // Frame as it will look once the bit on MOSI this edge is shifted in.
  assign frame_nxt      = {rx_data[FRAME_W-2:0], MOSI};
  assign unused_rx_msb  = rx_data[FRAME_W-1];
  assign unused_tx_bits = ^{tx_data[RESP_W-1], tx_data[RESP_W-3:0]};

  // Next-state, datapath control and registered-output next values.
  always_comb begin
    state_d      = state_q;
    miso_d       = miso_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = 1'b0;
    leds_d       = leds_q;
    frame_err_d  = frame_err_q;
    bit_cnt_d    = bit_cnt_q;
    tx_cnt_d     = tx_cnt_q;
    to_cnt_d     = to_cnt_q;
    rx_shift     = 1'b0;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;
    tx_load_data = TIMEOUT_RESP;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (!CS && MOSI) begin
          state_d     = S_RECV;
          miso_d      = 1'b1;
          bit_cnt_d   = '0;
          frame_err_d = 1'b0;
        end
      end

      S_RECV: begin
        if (CS) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else begin
          rx_shift = 1'b1;
          miso_d   = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d     = S_EXEC;
            miso_d      = 1'b0;
            alu_a_d     = frame_nxt[FRAME_W-1 -: OPERAND_W];
            alu_b_d     = frame_nxt[OPCODE_W +: OPERAND_W];
            alu_op_d    = frame_nxt[OPCODE_W-1:0];
            alu_start_d = 1'b1;
            to_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      S_EXEC: begin
        miso_d = 1'b0;
        if (CS) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (alu_done) begin
          // Completion beats a coinciding timeout.
          state_d      = S_RESP;
          tx_load      = 1'b1;
          tx_load_data = {alu_result, alu_flags};
          miso_d       = alu_result[OPERAND_W-1];
          leds_d       = alu_result;
          tx_cnt_d     = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d      = S_RESP;
          tx_load      = 1'b1;
          tx_load_data = TIMEOUT_RESP;
          miso_d       = TIMEOUT_RESP[RESP_W-1];
          frame_err_d  = 1'b1;
          tx_cnt_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end

      S_RESP: begin
        // The last bit completes regardless of CS.
        if (tx_cnt_q == TX_LAST) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end else if (CS) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else begin
          tx_shift = 1'b1;
          miso_d   = tx_data[RESP_W-2];
          tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_arduino) begin
    if (reset) begin
      state_q     <= S_IDLE;
      miso_q      <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      leds_q      <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      bit_cnt_q   <= '0;
      tx_cnt_q    <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      miso_q      <= miso_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      leds_q      <= leds_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign MISO      = miso_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_start = alu_start_q;
  assign leds      = leds_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_alu_sequencer.sv
// Directed bench for spi_alu_sequencer: handshake, exec, timeout, abort, reset and back-to-back frames.
module tb_spi_alu_sequencer;

  logic       clk;
  logic       reset;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_start;
  logic       alu_done;
  logic [3:0] alu_result;
  logic [3:0] alu_flags;
  logic [3:0] leds;
  logic       busy;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  int         alu_lat = -1;
  int         alu_wait = 0;
  logic       alu_armed = 1'b0;
  logic [3:0] alu_res = 4'h0;
  logic [3:0] alu_flg = 4'h0;

  spi_alu_sequencer #(.ALU_TIMEOUT(8)) dut (
    .clk_arduino (clk),
    .reset       (reset),
    .CS          (CS),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .leds        (leds),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign alu_result = alu_res;
  assign alu_flags  = alu_flg;

  // ALU model: done rises alu_lat cycles after the start pulse (0 = same cycle), lat<0 never.
  initial alu_done = 1'b0;
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (alu_start === 1'b1) begin
      start_cnt = start_cnt + 1;
      if (alu_lat >= 0) begin
        alu_armed = 1'b1;
        alu_wait  = alu_lat;
      end
    end
    if (alu_armed) begin
      if (alu_wait == 0) begin
        alu_done  = 1'b1;
        alu_armed = 1'b0;
      end else begin
        alu_wait = alu_wait - 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input logic cs, input logic mosi);
    @(negedge clk);
    CS   = cs;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [11:0] f);
    for (int i = 11; i >= 0; i--) step(1'b0, f[i]);
  endtask

  task automatic recv_resp(output logic [7:0] r);
    r[7] = MISO;
    for (int i = 6; i >= 0; i--) begin
      step(1'b0, 1'b0);
      r[i] = MISO;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; CS = 1'b1; MOSI = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
    n_checks++; if ({alu_a, alu_b, alu_op} !== 12'h000) begin n_fail++; $display("FAIL reset_alu: got %h%h%h want 000", alu_a, alu_b, alu_op); end
    n_checks++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", alu_start); end
    n_checks++; if (leds !== 4'h0) begin n_fail++; $display("FAIL reset_leds: got %h want 0", leds); end
    n_checks++; if ({busy, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_err: got %b want 00", {busy, frame_err}); end
  endtask

  task automatic test_basic;
    logic [11:0] frame;
    logic [7:0]  r;
    int          s0;
    frame = 12'b0011_0101_0000;
    alu_lat = 2; alu_res = 4'h8; alu_flg = 4'h0;
    s0 = start_cnt;
    step(1'b0, 1'b1);
    n_checks++; if ({MISO, busy} !== 2'b11) begin n_fail++; $display("FAIL basic_handshake: miso,busy=%b want 11", {MISO, busy}); end
    for (int i = 11; i >= 1; i--) begin
      step(1'b0, frame[i]);
      n_checks++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL basic_ack bit%0d: got %b want 1", i, MISO); end
    end
    step(1'b0, frame[0]);
    n_checks++; if ({alu_a, alu_b, alu_op} !== 12'h350) begin n_fail++; $display("FAIL basic_operands: got %h%h%h want 350", alu_a, alu_b, alu_op); end
    n_checks++; if ({alu_start, MISO} !== 2'b10) begin n_fail++; $display("FAIL basic_launch: start,miso=%b want 10", {alu_start, MISO}); end
    step(1'b0, 1'b0);
    n_checks++; if ({alu_start, MISO, leds} !== 6'b00_0000) begin n_fail++; $display("FAIL basic_exec1: start,miso,leds=%b want 000000", {alu_start, MISO, leds}); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_checks++; if (leds !== 4'h8) begin n_fail++; $display("FAIL basic_leds: got %h want 8", leds); end
    recv_resp(r);
    n_checks++; if (r !== 8'h80) begin n_fail++; $display("FAIL basic_resp: got %h want 80", r); end
    step(1'b0, 1'b0);
    n_checks++; if ({busy, MISO, frame_err} !== 3'b000) begin n_fail++; $display("FAIL basic_done: busy,miso,err=%b want 000", {busy, MISO, frame_err}); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL basic_start_pulses: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_timeout;
    logic [7:0] r;
    alu_lat = -1;
    step(1'b0, 1'b1);
    send_bits(12'h123);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b0);
      n_checks++; if ({MISO, frame_err, busy} !== 3'b001) begin n_fail++; $display("FAIL timeout_wait e%0d: miso,err,busy=%b want 001", k, {MISO, frame_err, busy}); end
    end
    step(1'b0, 1'b0);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", frame_err); end
    n_checks++; if (leds !== 4'h8) begin n_fail++; $display("FAIL timeout_leds: got %h want 8", leds); end
    recv_resp(r);
    n_checks++; if (r !== 8'hFF) begin n_fail++; $display("FAIL timeout_resp: got %h want ff", r); end
    step(1'b0, 1'b0);
    n_checks++; if ({busy, frame_err} !== 2'b01) begin n_fail++; $display("FAIL timeout_end: busy,err=%b want 01", {busy, frame_err}); end
  endtask

  task automatic test_abort;
    int s0;
    s0 = start_cnt;
    step(1'b0, 1'b1);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL abort_err_clear: got %b want 0", frame_err); end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    n_checks++; if ({busy, frame_err, MISO} !== 3'b010) begin n_fail++; $display("FAIL abort_idle: busy,err,miso=%b want 010", {busy, frame_err, MISO}); end
    n_checks++; if ({alu_a, alu_b, alu_op} !== 12'h123) begin n_fail++; $display("FAIL abort_hold: got %h%h%h want 123", alu_a, alu_b, alu_op); end
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    n_checks++; if ({busy, MISO, frame_err} !== 3'b001) begin n_fail++; $display("FAIL abort_stay: busy,miso,err=%b want 001", {busy, MISO, frame_err}); end
    n_checks++; if (start_cnt !== s0) begin n_fail++; $display("FAIL abort_no_start: got %0d want %0d", start_cnt, s0); end
  endtask

  task automatic test_reset_mid_resp;
    logic [7:0] r;
    alu_lat = 0; alu_res = 4'h6; alu_flg = 4'hA;
    step(1'b0, 1'b1);
    send_bits(12'h721);
    step(1'b0, 1'b0);
    n_checks++; if ({leds, MISO} !== 5'b0110_0) begin n_fail++; $display("FAIL rst_resp_entry: leds,miso=%b want 01100", {leds, MISO}); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_checks++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL rst_resp_bit3: got %b want 1", MISO); end
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    n_checks++; if ({MISO, busy, frame_err} !== 3'b000) begin n_fail++; $display("FAIL rst_mid: miso,busy,err=%b want 000", {MISO, busy, frame_err}); end
    n_checks++; if ({leds, alu_a} !== 8'h00) begin n_fail++; $display("FAIL rst_mid_regs: leds,a=%h want 00", {leds, alu_a}); end
    alu_lat = 1; alu_res = 4'h9; alu_flg = 4'h3;
    step(1'b0, 1'b1);
    send_bits(12'hA5C);
    n_checks++; if ({alu_a, alu_b, alu_op} !== 12'hA5C) begin n_fail++; $display("FAIL rst_fresh_ops: got %h%h%h want a5c", alu_a, alu_b, alu_op); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    recv_resp(r);
    n_checks++; if ({r, leds} !== 12'h939) begin n_fail++; $display("FAIL rst_fresh_resp: resp,leds=%h want 939", {r, leds}); end
    step(1'b0, 1'b0);
    n_checks++; if ({busy, frame_err} !== 2'b00) begin n_fail++; $display("FAIL rst_fresh_end: busy,err=%b want 00", {busy, frame_err}); end
  endtask

  task automatic test_idle_hold;
    logic [7:0] r;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      n_checks++; if ({MISO, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_hold e%0d: miso,busy=%b want 00", k, {MISO, busy}); end
    end
    step(1'b0, 1'b1);
    n_checks++; if ({MISO, busy} !== 2'b11) begin n_fail++; $display("FAIL idle_ack: miso,busy=%b want 11", {MISO, busy}); end
    alu_lat = 0; alu_res = 4'hC; alu_flg = 4'h1;
    send_bits(12'h442);
    step(1'b0, 1'b0);
    recv_resp(r);
    n_checks++; if (r !== 8'hC1) begin n_fail++; $display("FAIL idle_resp: got %h want c1", r); end
    step(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    alu_lat = 0; alu_res = 4'h2; alu_flg = 4'h4;
    step(1'b0, 1'b1);
    send_bits(12'h3C7);
    step(1'b0, 1'b0);
    n_checks++; if (leds !== 4'h2) begin n_fail++; $display("FAIL b2b_first_exec: leds=%h want 2", leds); end
    recv_resp(r);
    n_checks++; if (r !== 8'h24) begin n_fail++; $display("FAIL b2b_resp1: got %h want 24", r); end
    step(1'b0, 1'b1);
    n_checks++; if ({busy, MISO} !== 2'b00) begin n_fail++; $display("FAIL b2b_final_edge: busy,miso=%b want 00", {busy, MISO}); end
    alu_res = 4'h5; alu_flg = 4'h8;
    step(1'b0, 1'b1);
    n_checks++; if ({busy, MISO} !== 2'b11) begin n_fail++; $display("FAIL b2b_handshake2: busy,miso=%b want 11", {busy, MISO}); end
    send_bits(12'hE19);
    n_checks++; if ({alu_a, alu_b, alu_op, alu_start} !== 13'b1110_0001_1001_1) begin n_fail++; $display("FAIL b2b_ops2: got %h%h%h start=%b want e19 1", alu_a, alu_b, alu_op, alu_start); end
    step(1'b0, 1'b0);
    recv_resp(r);
    n_checks++; if ({r, leds} !== 12'h585) begin n_fail++; $display("FAIL b2b_resp2: resp,leds=%h want 585", {r, leds}); end
    step(1'b0, 1'b0);
    n_checks++; if ({busy, frame_err, MISO} !== 3'b000) begin n_fail++; $display("FAIL b2b_end: busy,err,miso=%b want 000", {busy, frame_err, MISO}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_abort();
    test_reset_mid_resp();
    test_idle_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
